// File: rtl/rl_ram_nr1w.sv
// Multi-read-port, single-write-port synchronous RAM with byte-accurate write-first bypass,
// read-enable output hold and an optional post-reset clear sequence.
// Optional macro RL_RAM_NR1W_OUTREG_EN adds one output register per read port (read latency 2).
module rl_ram_nr1w #(
  parameter int               ABITS          = 10,
  parameter int               DBITS          = 32,
  parameter int               RPORTS         = 2,
  parameter string            RW_CONTENTION  = "BYPASS",
  parameter bit               CLEAR_ON_RESET = 1'b1,
  parameter logic [DBITS-1:0] CLEAR_VALUE    = '0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      busy_o,
  input  logic [ABITS-1:0]          waddr_i,
  input  logic [DBITS-1:0]          din_i,
  input  logic                      we_i,
  input  logic [(DBITS+7)/8-1:0]    be_i,
  input  logic [RPORTS*ABITS-1:0]   raddr_i,
  input  logic [RPORTS-1:0]         re_i,
  output logic [RPORTS*DBITS-1:0]   dout_o
);

  localparam int LANES     = (DBITS + 7) / 8;
  localparam int DEPTH     = 2 ** ABITS;
  localparam bit BYPASS_EN = (RW_CONTENTION == "BYPASS");

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  // Expands lane enables to a per-bit mask; the top lane may be narrower than 8 bits.
  function automatic logic [DBITS-1:0] lane_mask(input logic [LANES-1:0] be);
    logic [DBITS-1:0] m;
    for (int i = 0; i < DBITS; i++) m[i] = be[i/8];
    return m;
  endfunction

  logic [0:0]       state;
  logic [ABITS-1:0] clr_cnt;
  logic             ready;

  assign ready  = (state == ST_READY);
  assign busy_o = (state == ST_CLEAR);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) state <= ST_READY;
    end
  end

  // Single physical write port shared by the clear sequencer and the user write.
  logic             wr_en;
  logic [ABITS-1:0] wr_addr;
  logic [DBITS-1:0] wr_data;
  logic [DBITS-1:0] wr_mask;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = waddr_i;
    wr_data = din_i;
    wr_mask = lane_mask(be_i);
    if (!rst_i) begin
      if (state == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_data = CLEAR_VALUE;
        wr_mask = '1;
      end else if (we_i) begin
        wr_en   = 1'b1;
      end
    end
  end

  logic [DBITS-1:0] mem [DEPTH];

  // NOTE: the array has no reset branch; initialisation is the clear sequencer's job.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < DBITS; i++) begin
        if (wr_mask[i]) mem[wr_addr][i] <= wr_data[i];
      end
    end
  end

  for (genvar p = 0; p < RPORTS; p++) begin : g_port
    logic [ABITS-1:0] ra;
    logic             rd_en;
    logic [DBITS-1:0] rd_q;
    logic [DBITS-1:0] rdata;

    assign ra    = raddr_i[p*ABITS +: ABITS];
    assign rd_en = re_i[p] & ready;

    // Array read returns the pre-write word; the bypass below merges the written lanes.
    always_ff @(posedge clk_i) begin
      if (rst_i)      rd_q <= '0;
      else if (rd_en) rd_q <= mem[ra];
    end

    if (BYPASS_EN) begin : g_byp
      logic             hit_q;
      logic [LANES-1:0] be_q;
      logic [DBITS-1:0] din_q;
      logic [DBITS-1:0] byp_mask;

      // Captured only on reads so the merged output holds along with rd_q.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          hit_q <= 1'b0;
          be_q  <= '0;
          din_q <= '0;
        end else if (rd_en) begin
          hit_q <= we_i && (ra == waddr_i);
          be_q  <= be_i;
          din_q <= din_i;
        end
      end

      assign byp_mask = hit_q ? lane_mask(be_q) : '0;
      assign rdata    = (rd_q & ~byp_mask) | (din_q & byp_mask);
    end else begin : g_nobyp
      assign rdata = rd_q;
    end

`ifdef RL_RAM_NR1W_OUTREG_EN
    logic             re_d;
    logic [DBITS-1:0] out_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        re_d  <= 1'b0;
        out_q <= '0;
      end else begin
        re_d <= rd_en;
        if (re_d) out_q <= rdata;
      end
    end

    assign dout_o[p*DBITS +: DBITS] = out_q;
`else
    assign dout_o[p*DBITS +: DBITS] = rdata;
`endif
  end

endmodule

// File: tb/tb_rl_ram_nr1w.sv
// Self-checking bench for rl_ram_nr1w (ABITS=4, DBITS=32, two read ports, clear to 0xA5A5A5A5).
// Follows RL_RAM_NR1W_OUTREG_EN to pick the expected read latency.
module tb_rl_ram_nr1w;

`ifdef RL_RAM_NR1W_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int          AB = 4;
  localparam int          DB = 32;
  localparam int          RP = 2;
  localparam int          NW = 16;
  localparam logic [31:0] CV = 32'hA5A5A5A5;

  logic           clk = 1'b0;
  logic           rst;
  logic           busy;
  logic [AB-1:0]  waddr;
  logic [DB-1:0]  din;
  logic           we;
  logic [3:0]     be;
  logic [RP*AB-1:0] raddr;
  logic [RP-1:0]  re;
  logic [RP*DB-1:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  rl_ram_nr1w #(
    .ABITS(AB), .DBITS(DB), .RPORTS(RP), .RW_CONTENTION("BYPASS"),
    .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(CV)
  ) dut (
    .clk_i(clk), .rst_i(rst), .busy_o(busy), .waddr_i(waddr), .din_i(din),
    .we_i(we), .be_i(be), .raddr_i(raddr), .re_i(re), .dout_o(dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: word array, clear countdown, and a per-port delivery pipe of LAT stages.
  logic [31:0] m_mem [NW];
  int          clr_left = 0;
  bit          started  = 0;
  logic [31:0] exp_dout [RP];
  bit          pv [RP][2];
  logic [31:0] pd [RP][2];

  always @(posedge clk) begin
    if (rst) begin
      clr_left = NW;
      started  = 1;
      for (int a = 0; a < NW; a++) m_mem[a] = CV;
      for (int p = 0; p < RP; p++) begin
        exp_dout[p] = '0;
        pv[p][0] = 0; pv[p][1] = 0;
        pd[p][0] = '0; pd[p][1] = '0;
      end
    end else if (started) begin
      bit          nv [RP];
      logic [31:0] nd [RP];
      for (int p = 0; p < RP; p++) begin nv[p] = 0; nd[p] = '0; end
      if (clr_left > 0) begin
        clr_left--;
      end else begin
        // Write-first: a read in the same cycle sees the freshly written lanes.
        if (we)
          for (int b = 0; b < 4; b++)
            if (be[b]) m_mem[waddr][8*b +: 8] = din[8*b +: 8];
        for (int p = 0; p < RP; p++)
          if (re[p]) begin nv[p] = 1; nd[p] = m_mem[raddr[p*AB +: AB]]; end
      end
      for (int p = 0; p < RP; p++) begin
        pv[p][1] = pv[p][0]; pd[p][1] = pd[p][0];
        pv[p][0] = nv[p];    pd[p][0] = nd[p];
        if (pv[p][LAT-1]) exp_dout[p] = pd[p][LAT-1];
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("busy", {31'd0, busy}, {31'd0, (clr_left > 0)});
      for (int p = 0; p < RP; p++)
        check(p == 0 ? "model_dout0" : "model_dout1", dout[p*DB +: DB], exp_dout[p]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    waddr = a; din = d; be = b; we = 1'b1;
    cyc();
    we = 1'b0; be = '0;
  endtask

  task automatic read_check(input int p, input logic [3:0] a, input logic [31:0] e, input string name);
    raddr[p*AB +: AB] = a;
    re[p] = 1'b1;
    cyc();
    re = '0;
    repeat (LAT - 1) cyc();
    check(name, dout[p*DB +: DB], e);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; we = 1'b0; be = '0; waddr = '0; din = '0; raddr = '0; re = '0;
    repeat (3) cyc();
    rst = 1'b0;

    // Clear after reset: exactly 16 busy cycles, then every word reads CLEAR_VALUE.
    count_busy(n);
    check("clear_cycles", n, 16);
    for (int a = 0; a < 8; a++) begin
      raddr = {4'(a + 8), 4'(a)}; re = 2'b11;
      cyc();
    end
    re = '0;
    repeat (LAT) cyc();
    read_check(0, 4'd0,  CV, "clear_word0");
    read_check(1, 4'd15, CV, "clear_word15");

    // Full-word write, then both ports read the same address.
    write(4'd3, 32'h11223344, 4'hF);
    raddr = {4'd3, 4'd3}; re = 2'b11;
    cyc();
    re = '0;
    repeat (LAT - 1) cyc();
    check("dual_read_p0", dout[31:0],  32'h11223344);
    check("dual_read_p1", dout[63:32], 32'h11223344);

    // Partial-lane contention bypass.
    write(4'd5, 32'hAABBCCDD, 4'hF);
    waddr = 4'd5; din = 32'h11223344; be = 4'b0101; we = 1'b1;
    raddr[AB-1:0] = 4'd5; re = 2'b01;
    cyc();
    we = 1'b0; be = '0; re = '0;
    repeat (LAT - 1) cyc();
    check("bypass_p0", dout[31:0], 32'hAA22CC44);
    read_check(0, 4'd5, 32'hAA22CC44, "after_bypass");

    // Output hold while writing the address being displayed.
    read_check(1, 4'd3, 32'h11223344, "hold_setup");
    for (int i = 0; i < 4; i++) begin
      waddr = 4'd3; din = 32'hDEADBEEF; be = 4'hF; we = 1'b1;
      cyc();
      check("hold_p1", dout[63:32], 32'h11223344);
    end
    we = 1'b0; be = '0;
    read_check(1, 4'd3, 32'hDEADBEEF, "latest_write");

    // Independent addresses per port; we_i with no lanes enabled is a no-op.
    write(4'd9, 32'h0BADF00D, 4'hF);
    write(4'd9, 32'hFFFFFFFF, 4'h0);
    raddr = {4'd9, 4'd5}; re = 2'b11;
    cyc();
    re = '0;
    repeat (LAT - 1) cyc();
    check("indep_p0", dout[31:0],  32'hAA22CC44);
    check("indep_p1", dout[63:32], 32'h0BADF00D);

    // Reset pulse at clear cycle 7 restarts the sequence.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("reset_dout0", dout[31:0], 32'h0);
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    count_busy(n);
    check("restart_cycles", n, 16);
    for (int a = 0; a < 8; a++) begin
      raddr = {4'(a + 8), 4'(a)}; re = 2'b11;
      cyc();
    end
    re = '0;
    repeat (LAT) cyc();
    read_check(0, 4'd3, CV, "recleared_word3");
    read_check(1, 4'd9, CV, "recleared_word9");

    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
